// File: rtl/light_scheduler.sv
`timescale 1ns/1ps
// Two-road phase scheduler: light sequencing, BCD countdown displays, manual override.
// Define LIGHT_SCHED_EXTEND_EN to compile in traffic-based green extension.
module light_scheduler #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned GREEN_TIME  = 30,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned EXTEND_TIME = 10,
    parameter int unsigned MAX_GREEN   = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       A,
    input  logic       B,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    output logic [1:0] A_Light,
    output logic [1:0] B_Light,
    output logic [3:0] A_Time_H,
    output logic [3:0] A_Time_L,
    output logic [3:0] B_Time_H,
    output logic [3:0] B_Time_L,
    output logic       Manual
);

    typedef enum logic [2:0] {
        ALLRED_A, A_GREEN, A_YELLOW, ALLRED_B, B_GREEN, B_YELLOW
    } phase_t;

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    G_T        = 7'(GREEN_TIME);
    localparam logic [6:0]    Y_T        = 7'(YELLOW_TIME);
    localparam logic [6:0]    AR_T       = 7'(ALLRED_TIME);
    localparam logic [8:0]    SUM_YA     = 9'(YELLOW_TIME + ALLRED_TIME);
    localparam logic [8:0]    SUM_ALL    = 9'(GREEN_TIME + YELLOW_TIME + ALLRED_TIME);
    localparam logic [8:0]    AR9        = 9'(ALLRED_TIME);

    logic [1:0]    a_sync, b_sync;
    logic          a_s, b_s;
    logic [PW-1:0] presc;
    logic          tick;
    phase_t        phase;
    logic [6:0]    cnt;
    logic          last_a, held, go_a;
    logic [8:0]    c9, a_raw, b_raw;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[0], A};
            b_sync <= {b_sync[0], B};
        end
    end

    assign a_s    = a_sync[1];
    assign b_s    = b_sync[1];
    assign Manual = a_s | b_s;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  presc <= '0;
        else if (tick) presc <= '0;
        else            presc <= presc + PW'(1);
    end

    assign tick = (presc == PRESC_LAST);

`ifdef LIGHT_SCHED_EXTEND_EN
    localparam logic [6:0] EX_T = 7'(EXTEND_TIME);
    localparam logic [6:0] MG_T = 7'(MAX_GREEN);

    logic [1:0] at_sync, bt_sync;
    logic [6:0] elapsed, elapsed_next, green_left, ext_load;
    logic       ext_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            at_sync <= '0;
            bt_sync <= '0;
        end else begin
            at_sync <= {at_sync[0], A_Traffic};
            bt_sync <= {bt_sync[0], B_Traffic};
        end
    end

    // elapsed_next includes the tick being evaluated
    assign elapsed_next = elapsed + 7'd1;
    assign green_left   = MG_T - elapsed_next;
    assign ext_load     = (EX_T < green_left) ? EX_T : green_left;
    assign ext_ok       = (elapsed_next < MG_T) &&
                          ((phase == A_GREEN) ? (at_sync[1] & ~bt_sync[1])
                                              : (bt_sync[1] & ~at_sync[1]));
`else
    logic traffic_unused;
    assign traffic_unused = A_Traffic ^ B_Traffic;
`endif

    // A release from a both-held all-red goes opposite the last green
    assign go_a = a_s | (~b_s & (held ? ~last_a : (phase == ALLRED_A)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase  <= ALLRED_A;
            cnt    <= AR_T;
            last_a <= 1'b0;
            held   <= 1'b0;
`ifdef LIGHT_SCHED_EXTEND_EN
            elapsed <= '0;
`endif
        end else begin
            case (phase)
                ALLRED_A, ALLRED_B: begin
                    if (a_s && b_s) begin
                        held <= 1'b1;
                    end else if (held || (tick && cnt == 7'd1)) begin
                        held   <= 1'b0;
                        phase  <= go_a ? A_GREEN : B_GREEN;
                        cnt    <= G_T;
                        last_a <= go_a;
`ifdef LIGHT_SCHED_EXTEND_EN
                        elapsed <= '0;
`endif
                    end else if (tick) begin
                        cnt <= cnt - 7'd1;
                    end
                end
                A_GREEN, B_GREEN: begin
                    if ((phase == A_GREEN) ? b_s : a_s) begin
                        phase <= (phase == A_GREEN) ? A_YELLOW : B_YELLOW;
                        cnt   <= Y_T;
                    end else if (!Manual && tick) begin
`ifdef LIGHT_SCHED_EXTEND_EN
                        elapsed <= elapsed_next;
`endif
                        if (cnt != 7'd1) begin
                            cnt <= cnt - 7'd1;
                        end
`ifdef LIGHT_SCHED_EXTEND_EN
                        else if (ext_ok) begin
                            cnt <= ext_load;
                        end
`endif
                        else begin
                            phase <= (phase == A_GREEN) ? A_YELLOW : B_YELLOW;
                            cnt   <= Y_T;
                        end
                    end
                end
                A_YELLOW, B_YELLOW: begin
                    if (tick) begin
                        if (cnt == 7'd1) begin
                            phase <= (phase == A_YELLOW) ? ALLRED_B : ALLRED_A;
                            cnt   <= AR_T;
                        end else begin
                            cnt <= cnt - 7'd1;
                        end
                    end
                end
                default: begin
                    phase <= ALLRED_A;
                    cnt   <= AR_T;
                    held  <= 1'b0;
                end
            endcase
        end
    end

    assign c9 = {2'b00, cnt};

    always_comb begin
        a_raw = c9;
        b_raw = c9;
        case (phase)
            ALLRED_A: b_raw = c9 + SUM_ALL;
            A_GREEN:  b_raw = c9 + SUM_YA;
            A_YELLOW: b_raw = c9 + AR9;
            B_GREEN:  a_raw = c9 + SUM_YA;
            B_YELLOW: a_raw = c9 + AR9;
            default: ;
        endcase
        if (Manual) begin
            case (phase)
                A_GREEN, A_YELLOW: b_raw = '0;
                B_GREEN, B_YELLOW: a_raw = '0;
                default: begin
                    a_raw = '0;
                    b_raw = '0;
                end
            endcase
        end
    end

    function automatic logic [7:0] to_bcd(input logic [8:0] v);
        logic [6:0] s;
        s = (v > 9'd99) ? 7'd99 : v[6:0];
        return {4'(s / 7'd10), 4'(s % 7'd10)};
    endfunction

    assign {A_Time_H, A_Time_L} = to_bcd(a_raw);
    assign {B_Time_H, B_Time_L} = to_bcd(b_raw);

    assign A_Light = (phase == A_GREEN) ? 2'b10 : (phase == A_YELLOW) ? 2'b01 : 2'b00;
    assign B_Light = (phase == B_GREEN) ? 2'b10 : (phase == B_YELLOW) ? 2'b01 : 2'b00;

endmodule
